// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
// One-hot state encoding, requester count and the default hold limit.
package arb_pkg;

  localparam int ARB_NUM_REQ       = 2;
  localparam int ARB_MAX_HOLD_DFLT = 8;

  // bit positions of the one-hot state vector
  localparam int ARB_B_IDLE = 0;
  localparam int ARB_B_OWN0 = 1;
  localparam int ARB_B_OWN1 = 2;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'b001,
    ARB_OWN0 = 3'b010,
    ARB_OWN1 = 3'b100
  } arb_state_e;

endpackage

// File: rtl/arb_hold_cnt.sv
// Saturating hold counter: clr wins over inc, at_limit flags MAX_HOLD-1.
// Ports: clk, reset (async high), clr, inc, at_limit (never set if MAX_HOLD==0).
module arb_hold_cnt #(
  parameter int HOLD_W   = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [HOLD_W-1:0] LIM =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + HOLD_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign at_limit = (MAX_HOLD != 0) && (cnt_q == LIM);

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter, registered one-hot grants, bounded hold.
// Ports: clk, reset, req_0/1 in; gnt_0/1, busy, preempt out; gnt_cnt_0/1 with ARB_GRANT_CNT_EN.
module rr_arbiter_2
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = ARB_MAX_HOLD_DFLT,
  parameter int HOLD_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req_0,
  input  logic req_1,
  output logic gnt_0,
  output logic gnt_1,
  output logic busy,
  output logic preempt
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt_0,
  output logic [CNT_W-1:0] gnt_cnt_1
`endif
);

  arb_state_e state_q, state_d;
  logic last_owner_q, last_owner_d;
  logic preempt_q, preempt_d;
  logic busy_q, busy_d;
  logic start0, start1;
  logic hold_inc, at_limit;

  always_comb begin
    state_d   = state_q;
    start0    = 1'b0;
    start1    = 1'b0;
    preempt_d = 1'b0;
    hold_inc  = 1'b0;
    unique case (1'b1)
      state_q[ARB_B_OWN0]: begin
        if (!req_0) begin
          if (req_1) start1 = 1'b1;
          else       state_d = ARB_IDLE;
        end else if (req_1) begin
          if (at_limit) begin
            start1    = 1'b1;
            preempt_d = 1'b1;
          end else begin
            hold_inc = 1'b1;
          end
        end
      end
      state_q[ARB_B_OWN1]: begin
        if (!req_1) begin
          if (req_0) start0 = 1'b1;
          else       state_d = ARB_IDLE;
        end else if (req_0) begin
          if (at_limit) begin
            start0    = 1'b1;
            preempt_d = 1'b1;
          end else begin
            hold_inc = 1'b1;
          end
        end
      end
      default: begin
        // tie goes to whoever did not own last
        if (req_0 && (!req_1 || last_owner_q))
          start0 = 1'b1;
        else if (req_1)
          start1 = 1'b1;
      end
    endcase
    if (start0) state_d = ARB_OWN0;
    if (start1) state_d = ARB_OWN1;
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (start0) last_owner_d = 1'b0;
    if (start1) last_owner_d = 1'b1;
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= 1'b1;
      preempt_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      preempt_q    <= preempt_d;
      busy_q       <= busy_d;
    end
  end

  arb_hold_cnt #(
    .HOLD_W   (HOLD_W),
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .clr      (start0 | start1),
    .inc      (hold_inc),
    .at_limit (at_limit)
  );

  assign gnt_0   = state_q[ARB_B_OWN0];
  assign gnt_1   = state_q[ARB_B_OWN1];
  assign busy    = busy_q;
  assign preempt = preempt_q;

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] gnt_cnt_0_q, gnt_cnt_0_d;
  logic [CNT_W-1:0] gnt_cnt_1_q, gnt_cnt_1_d;

  always_comb begin
    gnt_cnt_0_d = gnt_cnt_0_q;
    gnt_cnt_1_d = gnt_cnt_1_q;
    if (start0) gnt_cnt_0_d = gnt_cnt_0_q + CNT_W'(1);
    if (start1) gnt_cnt_1_d = gnt_cnt_1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_cnt_0_q <= '0;
      gnt_cnt_1_q <= '0;
    end else begin
      gnt_cnt_0_q <= gnt_cnt_0_d;
      gnt_cnt_1_q <= gnt_cnt_1_d;
    end
  end

  assign gnt_cnt_0 = gnt_cnt_0_q;
  assign gnt_cnt_1 = gnt_cnt_1_q;
`endif

endmodule

// File: tb/tb_rr_arbiter_2.sv
// Directed bench for rr_arbiter_2: vector table plus hand sequences.
// dut_a uses MAX_HOLD=8, dut_b MAX_HOLD=4; both share the same inputs.
module tb_rr_arbiter_2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_0 = 1'b0;
  logic req_1 = 1'b0;

  logic a_g0, a_g1, a_busy, a_pe;
  logic b_g0, b_g1, b_busy, b_pe;
`ifdef ARB_GRANT_CNT_EN
  logic [3:0] a_c0, a_c1;
  logic [3:0] b_c0, b_c1;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_arbiter_2 #(.MAX_HOLD(8), .HOLD_W(4), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .req_0(req_0), .req_1(req_1),
    .gnt_0(a_g0), .gnt_1(a_g1), .busy(a_busy), .preempt(a_pe)
`ifdef ARB_GRANT_CNT_EN
    , .gnt_cnt_0(a_c0), .gnt_cnt_1(a_c1)
`endif
  );

  rr_arbiter_2 #(.MAX_HOLD(4), .HOLD_W(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .req_0(req_0), .req_1(req_1),
    .gnt_0(b_g0), .gnt_1(b_g1), .busy(b_busy), .preempt(b_pe)
`ifdef ARB_GRANT_CNT_EN
    , .gnt_cnt_0(b_c0), .gnt_cnt_1(b_c1)
`endif
  );

  typedef struct {
    logic rst;
    logic r0;
    logic r1;
    logic g0;
    logic g1;
    logic pe;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input logic g0, input logic g1,
                       input logic pe);
    chk({nm, ".a"}, {28'd0, a_busy, a_pe, a_g1, a_g0},
        {28'd0, g0 | g1, pe, g1, g0});
  endtask

  task automatic chk_b(input string nm, input logic g0, input logic g1,
                       input logic pe);
    chk({nm, ".b"}, {28'd0, b_busy, b_pe, b_g1, b_g0},
        {28'd0, g0 | g1, pe, g1, g0});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst r0 r1 | g0 g1 pe
    tbl[0]  = '{0, 1, 0, 1, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 0, 0};
    tbl[2]  = '{0, 1, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 1, 1, 0, 0};
    tbl[7]  = '{0, 1, 1, 1, 0, 0};
    tbl[8]  = '{0, 1, 1, 1, 0, 0};
    tbl[9]  = '{0, 0, 1, 0, 1, 0};
    tbl[10] = '{0, 0, 1, 0, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 1, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0};
    tbl[16] = '{0, 1, 1, 0, 1, 0};
    tbl[17] = '{0, 1, 1, 0, 1, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 0};

    reset = 1'b1;
    repeat (3) tick();
    chk_a("rst", 1'b0, 1'b0, 1'b0);
    chk_b("rst", 1'b0, 1'b0, 1'b0);
`ifdef ARB_GRANT_CNT_EN
    chk("rst.cnt0", {28'd0, a_c0}, 32'd0);
    chk("rst.cnt1", {28'd0, a_c1}, 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      reset = tbl[i].rst;
      req_0 = tbl[i].r0;
      req_1 = tbl[i].r1;
      tick();
      chk_a($sformatf("tbl%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].pe);
    end

    // continuous contention on the MAX_HOLD=4 instance
    reset = 1'b1;
    req_0 = 1'b0;
    req_1 = 1'b0;
    tick();
    reset = 1'b0;
    req_0 = 1'b1;
    req_1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_b($sformatf("alt%0d", k),
            (((k - 1) / 4) % 2) == 0,
            (((k - 1) / 4) % 2) == 1,
            (k > 1) && (((k - 1) % 4) == 0));
    end

    // get master 1 onto the bus, then reset between edges
    req_0 = 1'b0;
    req_1 = 1'b1;
    tick();
    chk_b("pre_rst", 1'b0, 1'b1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk_b("async_rst", 1'b0, 1'b0, 1'b0);
    chk_a("async_rst", 1'b0, 1'b0, 1'b0);
    req_0 = 1'b1;
    req_1 = 1'b1;
    tick();
    chk_b("rst_hold", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_b("post_rst", 1'b1, 1'b0, 1'b0);
    chk_a("post_rst", 1'b1, 1'b0, 1'b0);

    // one-cycle req_1 pulse from idle
    req_0 = 1'b0;
    req_1 = 1'b0;
    tick();
    tick();
    chk_a("idle", 1'b0, 1'b0, 1'b0);
    req_1 = 1'b1;
    tick();
    req_1 = 1'b0;
    chk_a("pulse1", 1'b0, 1'b1, 1'b0);
    tick();
    chk_a("pulse2", 1'b0, 1'b0, 1'b0);

`ifdef ARB_GRANT_CNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int j = 0; j < 17; j++) begin
      req_0 = 1'b1;
      tick();
      req_0 = 1'b0;
      tick();
    end
    chk("cnt0_wrap", {28'd0, a_c0}, 32'd1);
    chk("cnt1_zero", {28'd0, a_c1}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
